mem_bus_arbiter: RTL and testbench

//  Shares the single data-memory port between two requesters: port 0 (CPU M-stage load/store) and port 1 (DMA/debug master).

---
 rtl/mem_bus_arbiter_pkg.sv | 25 ++
 rtl/mem_bus_arbiter_if.sv | 22 ++
 rtl/mem_bus_arbiter_picker.sv | 19 +
 rtl/mem_bus_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the two-port data-memory arbiter.
//  - FSM state encodings (2 bits)
//  - PRIO_MODE encodings
//  - legal RD_LAT range and the latency-counter helper
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    MEM_ARB_IDLE = 2'd0,
    MEM_ARB_BUSY = 2'd1,
    MEM_ARB_RESP = 2'd2
  } mem_arb_state_t;

  localparam int MEM_ARB_PRIO_RR = 0;  // round-robin on ties
  localparam int MEM_ARB_PRIO_P0 = 1;  // port 0 always wins ties

  localparam int MEM_ARB_RD_LAT_MIN = 1;
  localparam int MEM_ARB_RD_LAT_MAX = 7;
  localparam int MEM_ARB_CNT_W      = 3;

  // Counter load value: the counter runs RD_LAT-1 .. 0 across the BUSY cycles.
  function automatic logic [MEM_ARB_CNT_W-1:0] mem_arb_cnt_init(input int rd_lat);
    return MEM_ARB_CNT_W'(rd_lat - 1);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester-side bus of the data-memory arbiter (one instance per port).
//  master : the requester (CPU M-stage or DMA/debug) drives req/addr/wdata/byteen
//  slave  : the arbiter drives gnt/rvalid/rdata
//  req     request, held until gnt
//  addr    byte address
//  wdata   lane-aligned write data
//  byteen  byte enables, nonzero = write, zero = read
//  gnt     1-cycle accept pulse
//  rvalid  1-cycle completion pulse
//  rdata   read data while rvalid, 0 otherwise
interface mem_bus_arbiter_if;
  logic        req;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  byteen;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, wdata, byteen, input gnt, rvalid, rdata);
  modport slave  (input req, addr, wdata, byteen, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_bus_arbiter_picker.sv
// mem_arb_picker: combinational 2-way winner selection.
//  req0/req1  pending requests
//  last       last-grant pointer (0 = port 0 won last, 1 = port 1 won last)
//  prio_mode  1 = port 0 wins every tie, 0 = round-robin on ties
//  gnt0/gnt1  one-hot (or zero) winner
module mem_arb_picker (
  input  logic req0,
  input  logic req1,
  input  logic last,
  input  logic prio_mode,
  output logic gnt0,
  output logic gnt1
);

  // Port 0 wins when alone, in fixed-priority mode, or when port 1 had the last grant.
  assign gnt0 = req0 & (~req1 | prio_mode | last);
  assign gnt1 = req1 & ~gnt0;

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the single data-memory port between port 0 (CPU
// load/store) and port 1 (DMA/debug). One transaction at a time:
// IDLE (arbitrate, gnt) -> BUSY (RD_LAT cycles on memory) -> RESP (rvalid).
//  clk, reset      clock; synchronous active-high reset
//  p0, p1          requester buses (slave side)
//  mem_addr        address, held for every BUSY cycle
//  mem_wdata       write data, first BUSY cycle only
//  mem_byteen      write strobes, first BUSY cycle only
//  mem_rd          read strobe, first BUSY cycle only
//  mem_rdata       read data, sampled in the last BUSY cycle
// Optional macro MEM_ARB_PERF_EN adds perf_gnt0/perf_gnt1/perf_wait counters.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int RD_LAT    = 1,  // legal 1..7
  parameter int PRIO_MODE = 0
) (
  input  logic               clk,
  input  logic               reset,
  mem_bus_arbiter_if.slave   p0,
  mem_bus_arbiter_if.slave   p1,
  output logic [31:0]        mem_addr,
  output logic [31:0]        mem_wdata,
  output logic [3:0]         mem_byteen,
  output logic               mem_rd,
  input  logic [31:0]        mem_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]        perf_gnt0,
  output logic [31:0]        perf_gnt1,
  output logic [31:0]        perf_wait
`endif
);

  // Out-of-range latencies are clamped rather than producing a broken counter.
  localparam int RD_LAT_C = (RD_LAT < MEM_ARB_RD_LAT_MIN) ? MEM_ARB_RD_LAT_MIN :
                            (RD_LAT > MEM_ARB_RD_LAT_MAX) ? MEM_ARB_RD_LAT_MAX : RD_LAT;
  localparam logic [MEM_ARB_CNT_W-1:0] CNT_INIT = mem_arb_cnt_init(RD_LAT_C);

  mem_arb_state_t           state_reg, state_next;
  logic [MEM_ARB_CNT_W-1:0] cnt_reg, cnt_next;
  logic [31:0]              addr_reg, addr_next;
  logic [31:0]              wdata_reg, wdata_next;
  logic [31:0]              rdata_reg, rdata_next;
  logic [3:0]               byteen_reg, byteen_next;
  logic                     owner_reg, owner_next;
  logic                     last_reg, last_next;

  logic pick0, pick1, gnt0, gnt1;
  logic busy, first_busy, resp;

  mem_arb_picker u_picker (
    .req0      (p0.req),
    .req1      (p1.req),
    .last      (last_reg),
    .prio_mode (PRIO_MODE == MEM_ARB_PRIO_P0),
    .gnt0      (pick0),
    .gnt1      (pick1)
  );

  // Grants exist only in IDLE; masking with reset keeps a grant from being
  // signalled in a cycle whose latch is about to be discarded.
  assign gnt0 = (state_reg == MEM_ARB_IDLE) & pick0 & ~reset;
  assign gnt1 = (state_reg == MEM_ARB_IDLE) & pick1 & ~reset;

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    rdata_next  = rdata_reg;
    byteen_next = byteen_reg;
    owner_next  = owner_reg;
    last_next   = last_reg;
    case (state_reg)
      MEM_ARB_IDLE: begin
        if (gnt0 | gnt1) begin
          addr_next   = gnt1 ? p1.addr   : p0.addr;
          wdata_next  = gnt1 ? p1.wdata  : p0.wdata;
          byteen_next = gnt1 ? p1.byteen : p0.byteen;
          owner_next  = gnt1;
          last_next   = gnt1;
          cnt_next    = CNT_INIT;
          state_next  = MEM_ARB_BUSY;
        end
      end
      MEM_ARB_BUSY: begin
        if (cnt_reg == '0) begin
          rdata_next = (byteen_reg == 4'd0) ? mem_rdata : 32'd0;
          state_next = MEM_ARB_RESP;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      MEM_ARB_RESP: state_next = MEM_ARB_IDLE;
      default:      state_next = MEM_ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= MEM_ARB_IDLE;
      cnt_reg    <= '0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      rdata_reg  <= '0;
      byteen_reg <= '0;
      owner_reg  <= 1'b0;
      last_reg   <= 1'b1;  // port 0 wins the first tie
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
      rdata_reg  <= rdata_next;
      byteen_reg <= byteen_next;
      owner_reg  <= owner_next;
      last_reg   <= last_next;
    end
  end

  // The counter still holds its load value only in the first BUSY cycle.
  assign busy       = (state_reg == MEM_ARB_BUSY);
  assign first_busy = busy & (cnt_reg == CNT_INIT);
  assign resp       = (state_reg == MEM_ARB_RESP);

  assign mem_addr   = busy ? addr_reg : 32'd0;
  assign mem_wdata  = first_busy ? wdata_reg : 32'd0;
  assign mem_byteen = first_busy ? byteen_reg : 4'd0;
  assign mem_rd     = first_busy & (byteen_reg == 4'd0);

  assign p0.gnt    = gnt0;
  assign p1.gnt    = gnt1;
  assign p0.rvalid = resp & ~owner_reg;
  assign p1.rvalid = resp & owner_reg;
  assign p0.rdata  = (resp & ~owner_reg) ? rdata_reg : 32'd0;
  assign p1.rdata  = (resp & owner_reg) ? rdata_reg : 32'd0;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_gnt0_reg, perf_gnt1_reg, perf_wait_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_gnt0_reg <= '0;
      perf_gnt1_reg <= '0;
      perf_wait_reg <= '0;
    end else begin
      if (gnt0) perf_gnt0_reg <= perf_gnt0_reg + 32'd1;
      if (gnt1) perf_gnt1_reg <= perf_gnt1_reg + 32'd1;
      // One count per stalled cycle, however many ports are waiting.
      if ((p0.req | p1.req) & ~(gnt0 | gnt1)) perf_wait_reg <= perf_wait_reg + 32'd1;
    end
  end

  assign perf_gnt0 = perf_gnt0_reg;
  assign perf_gnt1 = perf_gnt1_reg;
  assign perf_wait = perf_wait_reg;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter. Two instances:
//  dut 0: RD_LAT=1, PRIO_MODE=0 (round robin)
//  dut 1: RD_LAT=3, PRIO_MODE=1 (port 0 wins ties)
// Stimulus pushes expected transactions into a per-dut queue; the negedge
// monitor pops one per observed gnt and then checks the memory strobes,
// address hold, rvalid timing and rdata against it.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic [31:0] mrd_a, mrd_b;
  logic [31:0] maddr_a, mwd_a, maddr_b, mwd_b;
  logic [3:0]  mbe_a, mbe_b;
  logic        mrs_a, mrs_b;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] pg0_a, pg1_a, pw_a, pg0_b, pg1_b, pw_b;
`endif

  mem_bus_arbiter_if ia0 ();
  mem_bus_arbiter_if ia1 ();
  mem_bus_arbiter_if ib0 ();
  mem_bus_arbiter_if ib1 ();

  mem_bus_arbiter #(.RD_LAT(1), .PRIO_MODE(0)) dut_a (
    .clk(clk), .reset(rst_a), .p0(ia0), .p1(ia1),
    .mem_addr(maddr_a), .mem_wdata(mwd_a), .mem_byteen(mbe_a), .mem_rd(mrs_a),
    .mem_rdata(mrd_a)
`ifdef MEM_ARB_PERF_EN
    , .perf_gnt0(pg0_a), .perf_gnt1(pg1_a), .perf_wait(pw_a)
`endif
  );

  mem_bus_arbiter #(.RD_LAT(3), .PRIO_MODE(1)) dut_b (
    .clk(clk), .reset(rst_b), .p0(ib0), .p1(ib1),
    .mem_addr(maddr_b), .mem_wdata(mwd_b), .mem_byteen(mbe_b), .mem_rd(mrs_b),
    .mem_rdata(mrd_b)
`ifdef MEM_ARB_PERF_EN
    , .perf_gnt0(pg0_b), .perf_gnt1(pg1_b), .perf_wait(pw_b)
`endif
  );

  typedef struct {
    int          port;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  be;
  } txn_t;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  txn_t txn_q[2][$];
  txn_t cur[2];
  bit   infl[2];
  int   t_gnt[2];
  bit   done_a = 0;
  bit   done_b = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic txn_t mk(input int p, input logic [31:0] a, wd, rd, input logic [3:0] be);
    txn_t t;
    t.port = p; t.addr = a; t.wdata = wd; t.rdata = rd; t.be = be;
    return t;
  endfunction

  task automatic chk(input int d, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL dut%0d %s cyc=%0d actual=%h required=%h", d, nm, cyc, act, exp);
    end
  endtask

  task automatic mon_step(input int d, input int lat, input logic rst,
                          input logic g0, g1, v0, v1, input logic [31:0] rd0, rd1,
                          input logic [31:0] maddr, mwd, input logic [3:0] mbe, input logic mrs);
    int   k;
    bit   busy_cyc, resp_cyc;
    txn_t e;
    busy_cyc = 0;
    resp_cyc = 0;
    if (!v0) chk(d, "p0_rdata_idle", rd0, 32'd0);
    if (!v1) chk(d, "p1_rdata_idle", rd1, 32'd0);
    if (g0 | g1) begin
      chk(d, "gnt_onehot", {31'd0, g0 & g1}, 32'd0);
      chk(d, "gnt_while_busy", {31'd0, infl[d]}, 32'd0);
      chk(d, "gnt_expected", 32'(txn_q[d].size() != 0), 32'd1);
      if (txn_q[d].size() != 0) begin
        e = txn_q[d].pop_front();
        chk(d, "gnt_port", {31'd0, g1}, 32'(e.port));
        cur[d]   = e;
        infl[d]  = 1;
        t_gnt[d] = cyc;
      end
    end else if (infl[d]) begin
      k = cyc - t_gnt[d];
      if (k >= 1 && k <= lat) begin
        busy_cyc = 1;
        chk(d, "mem_addr_hold", maddr, cur[d].addr);
        if (k == 1) begin
          chk(d, "mem_rd", {31'd0, mrs}, 32'(cur[d].be == 4'd0));
          chk(d, "mem_byteen", {28'd0, mbe}, {28'd0, cur[d].be});
          chk(d, "mem_wdata", mwd, cur[d].wdata);
        end else begin
          chk(d, "mem_rd_once", {31'd0, mrs}, 32'd0);
          chk(d, "mem_byteen_once", {28'd0, mbe}, 32'd0);
        end
      end else if (k == lat + 1) begin
        resp_cyc = 1;
        chk(d, "p0_rvalid", {31'd0, v0}, 32'(cur[d].port == 0));
        chk(d, "p1_rvalid", {31'd0, v1}, 32'(cur[d].port == 1));
        chk(d, "rdata", (cur[d].port == 1) ? rd1 : rd0, cur[d].rdata);
        $display("txn dut=%0d port=%0d addr=%h be=%h rdata=%h gnt@%0d rvalid@%0d",
                 d, cur[d].port, cur[d].addr, cur[d].be, (cur[d].port == 1) ? rd1 : rd0, t_gnt[d], cyc);
        infl[d] = 0;
      end
    end
    if (!busy_cyc) begin
      chk(d, "mem_addr_idle", maddr, 32'd0);
      chk(d, "mem_wdata_idle", mwd, 32'd0);
      chk(d, "mem_strobe_idle", {27'd0, mbe, mrs}, 32'd0);
    end
    if (!resp_cyc) chk(d, "rvalid_idle", {30'd0, v1, v0}, 32'd0);
    // A transaction caught by reset never completes.
    if (rst) infl[d] = 0;
  endtask

  always @(negedge clk) begin
    if (cyc >= 1) begin
      mon_step(0, 1, rst_a, ia0.gnt, ia1.gnt, ia0.rvalid, ia1.rvalid, ia0.rdata, ia1.rdata,
               maddr_a, mwd_a, mbe_a, mrs_a);
      mon_step(1, 3, rst_b, ib0.gnt, ib1.gnt, ib0.rvalid, ib1.rvalid, ib0.rdata, ib1.rdata,
               maddr_b, mwd_b, mbe_b, mrs_b);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input int p, input logic r, input logic [31:0] a, wd,
                       input logic [3:0] be);
    case ({d[0], p[0]})
      2'b00:   begin ia0.req = r; ia0.addr = a; ia0.wdata = wd; ia0.byteen = be; end
      2'b01:   begin ia1.req = r; ia1.addr = a; ia1.wdata = wd; ia1.byteen = be; end
      2'b10:   begin ib0.req = r; ib0.addr = a; ib0.wdata = wd; ib0.byteen = be; end
      default: begin ib1.req = r; ib1.addr = a; ib1.wdata = wd; ib1.byteen = be; end
    endcase
  endtask

  function automatic logic gnt_of(input int d, input int p);
    case ({d[0], p[0]})
      2'b00:   return ia0.gnt;
      2'b01:   return ia1.gnt;
      2'b10:   return ib0.gnt;
      default: return ib1.gnt;
    endcase
  endfunction

  // Returns at the negedge of the grant cycle.
  task automatic wait_gnt(input int d, input int p);
    bit got;
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = gnt_of(d, p);
    end
    chk(d, $sformatf("gnt_timeout_p%0d", p), {31'd0, got}, 32'd1);
  endtask

  task automatic wait_idle(input int d);
    bit ok;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      step();
      ok = (txn_q[d].size() == 0) && !infl[d];
    end
    chk(d, "drain_timeout", {31'd0, ok}, 32'd1);
  endtask

  // dut 0: RD_LAT=1, round robin
  initial begin
    rst_a = 1; mrd_a = 32'd0;
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    repeat (3) step();
    rst_a = 0;

    // Tie from reset with registered requesters that drop req one cycle after
    // seeing gnt: p0 wins at c0, p1 waits c1,c2, wins c3, still requests c4.
    mrd_a = 32'hCAFE0001;
    txn_q[0].push_back(mk(0, 32'h100, 32'h0, 32'hCAFE0001, 4'h0));
    txn_q[0].push_back(mk(1, 32'h104, 32'h11111111, 32'h0, 4'hF));
    drive(0, 0, 1, 32'h100, 32'h0, 4'h0);
    drive(0, 1, 1, 32'h104, 32'h11111111, 4'hF);
    fork
      begin wait_gnt(0, 0); step(); step(); drive(0, 0, 0, 0, 0, 0); end
      begin wait_gnt(0, 1); step(); step(); drive(0, 1, 0, 0, 0, 0); end
    join
    wait_idle(0);
`ifdef MEM_ARB_PERF_EN
    chk(0, "perf_gnt0", pg0_a, 32'd1);
    chk(0, "perf_gnt1", pg1_a, 32'd1);
    chk(0, "perf_wait", pw_a, 32'd3);
`endif

    // Single p0 read.
    mrd_a = 32'hDEADBEEF;
    txn_q[0].push_back(mk(0, 32'h10, 32'h0, 32'hDEADBEEF, 4'h0));
    drive(0, 0, 1, 32'h10, 32'h0, 4'h0);
    wait_gnt(0, 0); step(); drive(0, 0, 0, 0, 0, 0);
    wait_idle(0);

    // Single p1 write; nonzero memory data must not leak into rdata.
    mrd_a = 32'h12345678;
    txn_q[0].push_back(mk(1, 32'h20, 32'h0000BEEF, 32'h0, 4'b0011));
    drive(0, 1, 1, 32'h20, 32'h0000BEEF, 4'b0011);
    wait_gnt(0, 1); step(); drive(0, 1, 0, 0, 0, 0);
    wait_idle(0);

    // Both held for four transactions from reset: p0,p1,p0,p1.
    rst_a = 1; step(); step(); rst_a = 0;
    mrd_a = 32'h0BADF00D;
    for (int i = 0; i < 2; i++) begin
      txn_q[0].push_back(mk(0, 32'h40, 32'h0, 32'h0BADF00D, 4'h0));
      txn_q[0].push_back(mk(1, 32'h44, 32'hA5A5A5A5, 32'h0, 4'b1100));
    end
    drive(0, 0, 1, 32'h40, 32'h0, 4'h0);
    drive(0, 1, 1, 32'h44, 32'hA5A5A5A5, 4'b1100);
    wait_gnt(0, 0); wait_gnt(0, 1); wait_gnt(0, 0); wait_gnt(0, 1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    wait_idle(0);

    // p0 wins last, reset in BUSY aborts it and restores the pointer, so the
    // following tie must again go to p0.
    mrd_a = 32'h55AA55AA;
    txn_q[0].push_back(mk(0, 32'h80, 32'h0, 32'h55AA55AA, 4'h0));
    drive(0, 0, 1, 32'h80, 32'h0, 4'h0);
    wait_gnt(0, 0); step();
    drive(0, 0, 0, 0, 0, 0);
    rst_a = 1; step(); rst_a = 0;
    step();
    txn_q[0].push_back(mk(0, 32'h90, 32'h0, 32'h55AA55AA, 4'h0));
    txn_q[0].push_back(mk(1, 32'h94, 32'h22222222, 32'h0, 4'h2));
    drive(0, 0, 1, 32'h90, 32'h0, 4'h0);
    drive(0, 1, 1, 32'h94, 32'h22222222, 4'h2);
    fork
      begin wait_gnt(0, 0); step(); drive(0, 0, 0, 0, 0, 0); end
      begin wait_gnt(0, 1); step(); drive(0, 1, 0, 0, 0, 0); end
    join
    wait_idle(0);
    done_a = 1;
  end

  // dut 1: RD_LAT=3, port 0 priority
  initial begin
    rst_b = 1; mrd_b = 32'd0;
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    repeat (3) step();
    rst_b = 0;

    // p0 read, req dropped at T+1; address held 3 cycles, rvalid at T+4.
    mrd_b = 32'h13579BDF;
    txn_q[1].push_back(mk(0, 32'h30, 32'h0, 32'h13579BDF, 4'h0));
    drive(1, 0, 1, 32'h30, 32'h0, 4'h0);
    wait_gnt(1, 0); step(); drive(1, 0, 0, 0, 0, 0);
    wait_idle(1);

    // Both held: p0 four times, then p1 once p0 lets go.
    mrd_b = 32'h2468ACE0;
    for (int i = 0; i < 4; i++) txn_q[1].push_back(mk(0, 32'h50, 32'h0, 32'h2468ACE0, 4'h0));
    txn_q[1].push_back(mk(1, 32'h54, 32'h00000099, 32'h0, 4'h1));
    drive(1, 0, 1, 32'h50, 32'h0, 4'h0);
    drive(1, 1, 1, 32'h54, 32'h00000099, 4'h1);
    repeat (4) wait_gnt(1, 0);
    step(); drive(1, 0, 0, 0, 0, 0);
    wait_gnt(1, 1); step(); drive(1, 1, 0, 0, 0, 0);
    wait_idle(1);

    // p1 write aborted by reset in its 2nd BUSY cycle: no rvalid, idle outputs.
    txn_q[1].push_back(mk(1, 32'h64, 32'h77777777, 32'h0, 4'hF));
    drive(1, 1, 1, 32'h64, 32'h77777777, 4'hF);
    wait_gnt(1, 1); step();
    drive(1, 1, 0, 0, 0, 0);
    step();
    rst_b = 1; step(); rst_b = 0;
    repeat (3) step();
    txn_q[1].push_back(mk(0, 32'h70, 32'h0, 32'h2468ACE0, 4'h0));
    txn_q[1].push_back(mk(1, 32'h74, 32'h33333333, 32'h0, 4'h8));
    drive(1, 0, 1, 32'h70, 32'h0, 4'h0);
    drive(1, 1, 1, 32'h74, 32'h33333333, 4'h8);
    fork
      begin wait_gnt(1, 0); step(); drive(1, 0, 0, 0, 0, 0); end
      begin wait_gnt(1, 1); step(); drive(1, 1, 0, 0, 0, 0); end
    join
    wait_idle(1);
    done_b = 1;
  end

  initial begin
    bit fin;
    fin = 0;
    for (int i = 0; i < 5000 && !fin; i++) begin
      @(posedge clk);
      fin = done_a && done_b;
    end
    chk(0, "bench_timeout", {31'd0, fin}, 32'd1);
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
